// File: rtl/full_adder_dual_reg.sv
// Registered ripple-carry adder with two independent adder chains (gate-level and
// half-adder based). The results are cross-checked every cycle, with a sticky error flag.
module full_adder_dual_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             err_clr,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_ha,
  output logic             carry_ha,
  output logic             out_valid,
  output logic             mismatch,
  output logic             err_sticky
);

  logic [WIDTH-1:0] gl_s;
  logic             gl_co;
  logic [WIDTH-1:0] ha_s;
  logic             ha_co;
  logic [WIDTH:0]   gl_res;
  logic [WIDTH:0]   ha_res;
  logic             diff;

  // Gate-level full-adder chain. A procedural carry variable keeps the ripple
  // free of combinational self-loops on a packed vector.
  always_comb begin
    logic c;
    c    = C;
    gl_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gl_s[i] = A[i] ^ B[i] ^ c;
      c       = (A[i] & B[i]) | (A[i] & c) | (B[i] & c);
    end
    gl_co = c;
  end

  // Independent chain where each stage is two half adders plus an OR.
  always_comb begin
    logic c;
    logic p;
    logic g;
    logic t;
    c    = C;
    p    = 1'b0;
    g    = 1'b0;
    t    = 1'b0;
    ha_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      p       = A[i] ^ B[i];
      g       = A[i] & B[i];
      ha_s[i] = p ^ c;
      t       = p & c;
      c       = g | t;
    end
    ha_co = c;
  end

  assign gl_res = {gl_co, gl_s};
  assign ha_res = {ha_co, ha_s};
  assign diff   = (gl_res != ha_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum        <= '0;
      carry      <= 1'b0;
      sum_ha     <= '0;
      carry_ha   <= 1'b0;
      out_valid  <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      out_valid <= in_valid;
      mismatch  <= in_valid & diff;
      if (in_valid) begin
        {carry, sum}       <= gl_res;
        {carry_ha, sum_ha} <= ha_res;
      end
      // A clear takes priority over a mismatch seen on the same edge.
      if (err_clr) begin
        err_sticky <= 1'b0;
      end else if (in_valid && diff) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_dual_reg.sv
// Self-checking bench: directed truth table, ripple, hold, reset and error-flag steps,
// then a randomized run against an arithmetic reference.
module tb_full_adder_dual_reg;

  logic clk;
  logic rst_n;

  logic       v1, c1, clr1;
  logic [0:0] a1, b1;
  logic [0:0] s1, sh1;
  logic       co1, coh1, ov1, mm1, es1;

  logic       v8, c8, clr8;
  logic [7:0] a8, b8;
  logic [7:0] s8, sh8;
  logic       co8, coh8, ov8, mm8, es8;

  logic        v16, c16, clr16;
  logic [15:0] a16, b16;
  logic [15:0] s16, sh16;
  logic        co16, coh16, ov16, mm16, es16;

  int n_assert = 0;
  int n_fail   = 0;

  full_adder_dual_reg #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .C(c1), .err_clr(clr1),
    .sum(s1), .carry(co1), .sum_ha(sh1), .carry_ha(coh1), .out_valid(ov1),
    .mismatch(mm1), .err_sticky(es1)
  );

  full_adder_dual_reg #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8), .C(c8), .err_clr(clr8),
    .sum(s8), .carry(co8), .sum_ha(sh8), .carry_ha(coh8), .out_valid(ov8),
    .mismatch(mm8), .err_sticky(es8)
  );

  full_adder_dual_reg #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .A(a16), .B(b16), .C(c16), .err_clr(clr16),
    .sum(s16), .carry(co16), .sum_ha(sh16), .carry_ha(coh16), .out_valid(ov16),
    .mismatch(mm16), .err_sticky(es16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    v8 = v; a8 = a; b8 = b; c8 = c;
  endtask

  initial begin
    logic [1:0]  e1;
    logic [8:0]  e8;
    logic [16:0] e16;
    logic        eov16;

    v1 = 0; a1 = 0; b1 = 0; c1 = 0; clr1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0; clr8 = 0;
    v16 = 0; a16 = 0; b16 = 0; c16 = 0; clr16 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_w8_sum", {co8, s8}, 0);
    chk("rst_w8_ha", {coh8, sh8}, 0);
    chk("rst_w8_flags", {ov8, mm8, es8}, 0);
    chk("rst_w1_all", {co1, s1, coh1, sh1, ov1, mm1, es1}, 0);
    chk("rst_w16_all", {co16, s16, coh16, sh16, ov16, mm16, es16}, 0);
    #19 rst_n = 1'b1;
    tick();

    // Full-adder truth table on the 1-bit instance.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      v1 = 1; a1 = abc[2]; b1 = abc[1]; c1 = abc[0];
      e1 = 2'(abc[2]) + 2'(abc[1]) + 2'(abc[0]);
      tick();
      chk("tt_gate", {co1, s1}, e1);
      chk("tt_ha", {coh1, sh1}, e1);
      chk("tt_flags", {ov1, mm1, es1}, 3'b100);
    end
    v1 = 0;

    // Carry ripple on the 8-bit instance.
    drive8(1, 8'hFF, 8'h00, 1);
    tick();
    chk("ripple_ff", {ov8, co8, s8}, {1'b1, 9'h100});
    chk("ripple_ff_ha", {coh8, sh8}, 9'h100);
    drive8(1, 8'h80, 8'h80, 0);
    tick();
    chk("ripple_80", {ov8, co8, s8}, {1'b1, 9'h100});
    drive8(1, 8'h55, 8'hAA, 0);
    tick();
    chk("ripple_55", {ov8, co8, s8, mm8}, {1'b1, 9'h0FF, 1'b0});

    // Hold while in_valid is low.
    drive8(1, 8'h1E, 8'h1E, 0);
    tick();
    chk("hold_load", {ov8, co8, s8}, {1'b1, 9'h03C});
    for (int i = 0; i < 3; i++) begin
      drive8(0, 8'(8'h11 * (i + 3)), 8'(8'h27 + i), 1'(i));
      tick();
      chk("hold_flags", {ov8, mm8}, 2'b00);
      chk("hold_sum", {co8, s8, coh8, sh8}, {9'h03C, 9'h03C});
    end

    // Asynchronous reset in mid-cycle.
    drive8(1, 8'hFF, 8'h00, 0);
    tick();
    chk("arst_pre", {ov8, co8, s8}, {1'b1, 9'h0FF});
    drive8(0, 8'h00, 8'h00, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sum", {co8, s8, coh8, sh8}, 0);
    chk("arst_flags", {ov8, mm8, es8}, 0);
    #1 rst_n = 1'b1;
    drive8(1, 8'h12, 8'h34, 1);
    tick();
    chk("arst_after", {ov8, co8, s8, coh8, sh8}, {1'b1, 9'h047, 9'h047});

    // Fault injection into the half-adder path.
    force u8.ha_res = 9'h000;
    drive8(1, 8'h05, 8'h03, 0);
    tick();
    chk("fault_mm", {mm8, es8}, 2'b11);
    chk("fault_gate", {co8, s8}, 9'h008);
    release u8.ha_res;
    drive8(1, 8'h40, 8'h02, 0);
    tick();
    chk("fault_sticky", {mm8, es8, co8, s8}, {2'b01, 9'h042});
    drive8(0, 8'h00, 8'h00, 0);
    tick();
    chk("fault_sticky_idle", {mm8, es8}, 2'b01);
    clr8 = 1;
    tick();
    chk("err_clr", es8, 1'b0);
    force u8.ha_res = 9'h1FF;
    drive8(1, 8'h01, 8'h01, 0);
    tick();
    chk("clr_vs_fault", {mm8, es8}, 2'b10);
    release u8.ha_res;
    clr8 = 0;
    drive8(1, 8'h02, 8'h02, 0);
    tick();
    chk("post_clr", {mm8, es8, co8, s8}, {2'b00, 9'h004});
    drive8(0, 8'h00, 8'h00, 0);

    // Randomized run on the 16-bit instance against plain arithmetic.
    e16 = 17'h0;
    for (int n = 0; n < 10000; n++) begin
      v16 = 1'($urandom_range(0, 3) != 0);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      if (v16) e16 = 17'(a16) + 17'(b16) + 17'(c16);
      eov16 = v16;
      tick();
      chk("rnd_valid", ov16, eov16);
      chk("rnd_gate", {co16, s16}, e16);
      chk("rnd_ha", {coh16, sh16}, e16);
      chk("rnd_flags", {mm16, es16}, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder_dual_reg.md
Name: full_adder_dual_reg

Overview:
- Registered, parameterisable ripple-carry adder.
- Computes A + B + C through two independent structures:
  - a direct gate-level full-adder chain;
  - a chain of full adders each built from two half adders plus an OR.
- Registers both results and flags any disagreement between them.
- Used as a self-checking arithmetic leaf in datapaths, and as the reference for the full-adder truth table.

Parameters:
- WIDTH, 1, operand width in bits (legal 1..64); one full-adder stage per bit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies A/B/C this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- C  input  1  carry-in to bit 0.
- err_clr  input  1  synchronous clear of the sticky error flag.
- sum  output  WIDTH  sum from the gate-level chain, registered.
- carry  output  1  carry-out from the gate-level chain, registered.
- sum_ha  output  WIDTH  sum from the half-adder chain, registered.
- carry_ha  output  1  carry-out from the half-adder chain, registered.
- out_valid  output  1  sum/carry/sum_ha/carry_ha hold a new result.
- mismatch  output  1  the two paths disagreed on the current result (pulse).
- err_sticky  output  1  latched OR of mismatch since reset or the last err_clr.

Behaviour:
- Gate-level stage i:
  - s_i = a_i ^ b_i ^ c_i;
  - co_i = (a_i & b_i) | (a_i & c_i) | (b_i & c_i).
- Half-adder stage i:
  - HA1 gives p = a_i ^ b_i and g = a_i & b_i;
  - HA2 gives s_i = p ^ c_i and t = p & c_i;
  - co_i = g | t.
- Chaining: c_0 = C and c_{i+1} = co_i in each chain. Each chain is built separately; no logic is shared between chains.
- Arithmetic result: {carry, sum} = A + B + C, exactly WIDTH+1 bits, unsigned. Same for {carry_ha, sum_ha}.
- Latency: 1 cycle. With in_valid=1 at edge k, results appear after edge k with out_valid=1.
- With in_valid=0 at an edge:
  - out_valid goes to 0 and mismatch goes to 0;
  - sum/carry/sum_ha/carry_ha hold their previous values.
- mismatch is registered with the results: set when in_valid=1 and {carry,sum} != {carry_ha,sum_ha} (computed combinationally), else 0.
- err_sticky update per edge:
  - if err_clr: err_sticky <= 0;
  - else if the mismatch condition is true this edge: err_sticky <= 1;
  - else hold.
  - When err_clr and a new mismatch occur on the same edge, err_clr wins: the flag is 0 after that edge, and mismatch still pulses.
- Reset: while rst_n=0, every output is 0 regardless of clk. This covers sum, carry, sum_ha, carry_ha, out_valid, mismatch and err_sticky. Assertion mid-operation discards any in-flight result immediately.
- Reset release: the first edge with rst_n=1 samples inputs normally.
- Inputs carrying X/Z are outside the specified behaviour.
- No internal pipelining beyond the single output register stage. The combinational path is a WIDTH-deep ripple.

Test Plan:
- Exhaustive truth table, WIDTH=1: apply (A,B,C) in the sequence 000, 001, 010, 011, 100, 101, 110, 111 with in_valid=1, one per cycle. Required (carry,sum): 00, 01, 01, 10, 01, 10, 10, 11. carry_ha/sum_ha are identical each time, mismatch=0 and err_sticky=0 throughout.
- Carry ripple, WIDTH=8: A=8'hFF, B=8'h00, C=1 -> sum=8'h00, carry=1 one cycle later. Then A=8'h80, B=8'h80, C=0 -> sum=8'h00, carry=1. Then A=8'h55, B=8'hAA, C=0 -> sum=8'hFF, carry=0.
- Hold behaviour: after a valid result of 8'h3C, drop in_valid for 3 cycles while changing A/B. Required: out_valid=0, sum stays 8'h3C, mismatch=0.
- Async reset: assert rst_n=0 between clock edges while sum=8'hFF and out_valid=1. All outputs read 0 before the next edge. After release, the first valid input produces a correct result one cycle later.
- Error flag:
  - force a discrepancy in the half-adder path (bench force/fault injection) -> mismatch pulses 1 for one cycle, err_sticky=1 and stays 1;
  - err_clr=1 for one cycle -> err_sticky=0;
  - err_clr coincident with a new fault -> err_sticky=0 after that edge.
- Random: 10,000 random A/B/C with random in_valid, WIDTH=16. Every valid result must satisfy {carry,sum} = A+B+C, and mismatch must never assert without fault injection.
